// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : next-PC generator with its own PC register and a fetch-side
//          valid/ready handshake.
//
// pc_gen supplies sequential fetch addresses to the IFU. It also accepts one
// redirect per cycle from EXU/CSR. Around the plain next-PC mux it adds boot
// sequencing, halt, misaligned-target trapping and redirect priority.
//
// Ports
//   clk             in   1     clock, rising edge
//   rst_n           in   1     asynchronous, active-low reset
//   pc_o            out  XLEN  current fetch address
//   pc_valid_o      out  1     pc_o offered to IFU
//   pc_ready_i      in   1     IFU accepts pc_o this cycle
//   redir_valid_i   in   1     redirect request, single-cycle pulse
//   redir_sel_i     in   2     0: base_pc+imm  1: (rf_busA+imm)&~1
//                              2: csr_busA     3: imm (absolute)
//   redir_base_pc_i in   XLEN  PC of the redirecting instruction
//   rf_busA_i       in   XLEN  register-file operand
//   csr_busA_i      in   XLEN  CSR operand (mtvec/mepc)
//   imm_i           in   XLEN  sign-extended immediate
//   halt_i          in   1     stop fetching
//   misalign_o      out  1     one-cycle pulse: redirect target misaligned
//   misalign_addr_o out  XLEN  offending target, held until next misalign
//
// Optional build macro PC_GEN_PERF_EN adds two 64-bit counters:
//   perf_fetch_o    out  64    number of fetch handshakes
//   perf_redir_o    out  64    number of aligned redirects taken
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h8000_0000,
    parameter int              INST_BYTES = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            redir_valid_i,
    input  logic [1:0]      redir_sel_i,
    input  logic [XLEN-1:0] redir_base_pc_i,
    input  logic [XLEN-1:0] rf_busA_i,
    input  logic [XLEN-1:0] csr_busA_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic            halt_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
`ifdef PC_GEN_PERF_EN
    ,
    output logic [63:0]     perf_fetch_o,
    output logic [63:0]     perf_redir_o
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            pc_valid_reg;
    logic            misalign_reg;
    logic [XLEN-1:0] misalign_addr_reg;

    // -------------------------------------------------------------------------
    // Redirect target arithmetic. All adds are modulo 2^XLEN and the carry
    // is simply dropped.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] branch_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] pc_inc;

    assign branch_sum  = redir_base_pc_i + imm_i;
    assign jalr_sum    = rf_busA_i + imm_i;
    // jalr drops bit 0 of the sum. The alignment check below runs after this.
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    assign pc_inc      = pc_reg + XLEN'(INST_BYTES);

    always_comb begin
        redir_target = branch_sum;
        case (redir_sel_i)
            2'd0:    redir_target = branch_sum;
            2'd1:    redir_target = jalr_target;
            2'd2:    redir_target = csr_busA_i;
            2'd3:    redir_target = imm_i;
            default: redir_target = branch_sum;
        endcase
    end

    // -------------------------------------------------------------------------
    // Alignment check: every one of the low ALIGN_BITS target bits must be 0.
    // -------------------------------------------------------------------------
    logic [ALIGN_BITS-1:0] low_bits;
    logic                  target_misaligned;

    genvar gi;
    generate
        for (gi = 0; gi < ALIGN_BITS; gi = gi + 1) begin : g_low_bits
            assign low_bits[gi] = redir_target[gi];
        end
    endgenerate

    assign target_misaligned = |low_bits;

    // Qualified events used by the FSM and by the counters.
    logic handshake;
    logic redir_ok;
    logic redir_bad;

    assign handshake = pc_valid_reg & pc_ready_i;
    assign redir_ok  = redir_valid_i & ~target_misaligned;
    assign redir_bad = redir_valid_i &  target_misaligned;

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs.
    //   BOOT : one dead cycle after reset. pc holds RESET_VEC and all inputs
    //          are ignored.
    //   RUN  : pc offered. A redirect takes priority over the increment. A
    //          handshake in the same cycle still consumed the old pc.
    //   HALT : nothing offered. Only an aligned redirect with halt_i low
    //          returns the FSM to RUN.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_BOOT;
            pc_reg            <= RESET_VEC;
            pc_valid_reg      <= 1'b0;
            misalign_reg      <= 1'b0;
            misalign_addr_reg <= '0;
        end else begin
            // misalign_o is a pulse, so it is low unless set again below.
            misalign_reg <= 1'b0;

            case (state_reg)
                ST_BOOT: begin
                    state_reg    <= ST_RUN;
                    pc_valid_reg <= 1'b1;
                end

                ST_RUN: begin
                    if (redir_bad) begin
                        // A bad target leaves pc where it was and stops fetch.
                        misalign_reg      <= 1'b1;
                        misalign_addr_reg <= redir_target;
                        state_reg         <= ST_HALT;
                        pc_valid_reg      <= 1'b0;
                    end else begin
                        if (redir_ok) begin
                            pc_reg <= redir_target;
                        end else if (handshake) begin
                            pc_reg <= pc_inc;
                        end
                        if (halt_i) begin
                            state_reg    <= ST_HALT;
                            pc_valid_reg <= 1'b0;
                        end
                    end
                end

                ST_HALT: begin
                    if (redir_bad) begin
                        misalign_reg      <= 1'b1;
                        misalign_addr_reg <= redir_target;
                    end else if (redir_ok) begin
                        // The target always loads. The FSM resumes only when
                        // halt_i is no longer asserted.
                        pc_reg <= redir_target;
                        if (!halt_i) begin
                            state_reg    <= ST_RUN;
                            pc_valid_reg <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg    <= ST_BOOT;
                    pc_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o            = pc_reg;
    assign pc_valid_o      = pc_valid_reg;
    assign misalign_o      = misalign_reg;
    assign misalign_addr_o = misalign_addr_reg;

`ifdef PC_GEN_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters. They wrap silently at 2^64.
    // -------------------------------------------------------------------------
    logic [63:0] perf_fetch_reg;
    logic [63:0] perf_redir_reg;
    logic        redir_taken;

    // An aligned redirect takes effect in RUN and HALT. In BOOT it is ignored.
    assign redir_taken = redir_ok & (state_reg != ST_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_reg <= 64'd0;
            perf_redir_reg <= 64'd0;
        end else begin
            if (handshake) begin
                perf_fetch_reg <= perf_fetch_reg + 64'd1;
            end
            if (redir_taken) begin
                perf_redir_reg <= perf_redir_reg + 64'd1;
            end
        end
    end

    assign perf_fetch_o = perf_fetch_reg;
    assign perf_redir_o = perf_redir_reg;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen : scoreboard bench for pc_gen.
//
// The driver issues directed vectors. For each one it pushes the hand-computed
// fetch address or misalign address onto a queue. A monitor pops a queue entry
// whenever the DUT shows a handshake or a misalign pulse, and compares it.
// Invariants that have no output event, such as reset values, hold, and HALT
// with valid low, are compared directly by the driver.
// -----------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i;
    logic        redir_valid_i;
    logic [1:0]  redir_sel_i;
    logic [31:0] redir_base_pc_i;
    logic [31:0] rf_busA_i;
    logic [31:0] csr_busA_i;
    logic [31:0] imm_i;
    logic        halt_i;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`ifdef PC_GEN_PERF_EN
    logic [63:0] perf_fetch_o;
    logic [63:0] perf_redir_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] fetch_q[$];
    logic [31:0] mis_q[$];

    pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .pc_ready_i      (pc_ready_i),
        .redir_valid_i   (redir_valid_i),
        .redir_sel_i     (redir_sel_i),
        .redir_base_pc_i (redir_base_pc_i),
        .rf_busA_i       (rf_busA_i),
        .csr_busA_i      (csr_busA_i),
        .imm_i           (imm_i),
        .halt_i          (halt_i),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
`ifdef PC_GEN_PERF_EN
        ,
        .perf_fetch_o    (perf_fetch_o),
        .perf_redir_o    (perf_redir_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Advance to just after the next active edge. Inputs change only here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, away from input changes.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pc_valid_o && pc_ready_i) begin
                    if (fetch_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch: unexpected handshake at pc %h, expected none", pc_o);
                    end else begin
                        e = fetch_q.pop_front();
                        check("fetch", {32'd0, pc_o}, {32'd0, e});
                    end
                end
                if (misalign_o) begin
                    if (mis_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL misalign: unexpected pulse addr %h, expected none", misalign_addr_o);
                    end else begin
                        e = mis_q.pop_front();
                        check("misalign_addr", {32'd0, misalign_addr_o}, {32'd0, e});
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        pc_ready_i      = 1'b1;
        redir_valid_i   = 1'b0;
        redir_sel_i     = 2'd0;
        redir_base_pc_i = '0;
        rf_busA_i       = '0;
        csr_busA_i      = '0;
        imm_i           = '0;
        halt_i          = 1'b0;

        // ---- reset state
        repeat (3) cyc();
        @(negedge clk);
        check("rst_pc",       pc_o,            32'h8000_0000);
        check("rst_valid",    pc_valid_o,      1'b0);
        check("rst_misalign", misalign_o,      1'b0);
        check("rst_mis_addr", misalign_addr_o, 32'h0);
`ifdef PC_GEN_PERF_EN
        check("rst_perf_fetch", perf_fetch_o, 64'd0);
        check("rst_perf_redir", perf_redir_o, 64'd0);
`endif
        cyc();

        // ---- reset release: one BOOT cycle, then sequential fetch
        fetch_q.push_back(32'h8000_0000);
        fetch_q.push_back(32'h8000_0004);
        fetch_q.push_back(32'h8000_0008);
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_valid", pc_valid_o, 1'b0);
        check("boot_pc",    pc_o,       32'h8000_0000);
        repeat (4) cyc();          // pc now 8000_000C

        // ---- back-pressure: pc holds with valid high
        pc_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_pc",    pc_o,       32'h8000_000C);
            check("hold_valid", pc_valid_o, 1'b1);
            cyc();
        end
        pc_ready_i = 1'b1;
        fetch_q.push_back(32'h8000_000C);
        cyc();                     // pc now 8000_0010

        // ---- branch with same-cycle handshake: redirect beats increment
        redir_sel_i     = 2'd0;
        redir_base_pc_i = 32'h8000_0010;
        imm_i           = 32'hFFFF_FFF0;
        redir_valid_i   = 1'b1;
        fetch_q.push_back(32'h8000_0010);
        cyc();
        redir_valid_i = 1'b0;
        fetch_q.push_back(32'h8000_0000);
        cyc();                     // pc now 8000_0004

        // ---- jalr aligned: (8000_0101 + 3) & ~1 = 8000_0104
        pc_ready_i    = 1'b0;
        redir_sel_i   = 2'd1;
        rf_busA_i     = 32'h8000_0101;
        imm_i         = 32'h0000_0003;
        redir_valid_i = 1'b1;
        cyc();
        redir_valid_i = 1'b0;
        @(negedge clk);
        check("jalr_pc",    pc_o,       32'h8000_0104);
        check("jalr_valid", pc_valid_o, 1'b1);
        cyc();
        pc_ready_i = 1'b1;
        fetch_q.push_back(32'h8000_0104);
        cyc();                     // pc now 8000_0108

        // ---- jalr misaligned: (8000_0101 + 1) & ~1 = 8000_0102
        pc_ready_i    = 1'b0;
        imm_i         = 32'h0000_0001;
        redir_valid_i = 1'b1;
        mis_q.push_back(32'h8000_0102);
        cyc();
        redir_valid_i = 1'b0;
        @(negedge clk);
        check("misal_pc",    pc_o,       32'h8000_0108);
        check("misal_valid", pc_valid_o, 1'b0);
        cyc();
        @(negedge clk);
        check("misal_pulse_end", misalign_o,      1'b0);
        check("misal_addr_hold", misalign_addr_o, 32'h8000_0102);
        cyc();

        // ---- trap from HALT with halt_i low: back to RUN
        pc_ready_i    = 1'b1;
        redir_sel_i   = 2'd2;
        csr_busA_i    = 32'h8000_1000;
        redir_valid_i = 1'b1;
        fetch_q.push_back(32'h8000_1000);
        cyc();
        redir_valid_i = 1'b0;
        cyc();                     // pc now 8000_1004

        // ---- halt_i from RUN
        pc_ready_i = 1'b0;
        halt_i     = 1'b1;
        cyc();
        @(negedge clk);
        check("halt_valid", pc_valid_o, 1'b0);
        check("halt_pc",    pc_o,       32'h8000_1004);
        cyc();

        // ---- trap while halt_i held: target loads, stays HALT
        csr_busA_i    = 32'h8000_2000;
        redir_valid_i = 1'b1;
        cyc();
        redir_valid_i = 1'b0;
        @(negedge clk);
        check("trap_halt_pc",    pc_o,       32'h8000_2000);
        check("trap_halt_valid", pc_valid_o, 1'b0);
        cyc();
        halt_i = 1'b0;
        cyc();
        @(negedge clk);
        check("halt_no_redir_valid", pc_valid_o, 1'b0);
        cyc();

        // ---- misaligned absolute target while in HALT
        redir_sel_i   = 2'd3;
        imm_i         = 32'h0000_0006;
        redir_valid_i = 1'b1;
        mis_q.push_back(32'h0000_0006);
        cyc();
        redir_valid_i = 1'b0;
        @(negedge clk);
        check("halt_misal_pc",    pc_o,       32'h8000_2000);
        check("halt_misal_valid", pc_valid_o, 1'b0);
        cyc();

        // ---- wrap: FFFF_FFFC + 4 = 0
        pc_ready_i    = 1'b1;
        imm_i         = 32'hFFFF_FFFC;
        redir_valid_i = 1'b1;
        fetch_q.push_back(32'hFFFF_FFFC);
        fetch_q.push_back(32'h0000_0000);
        cyc();
        redir_valid_i = 1'b0;
        cyc();                     // pc now 0
        cyc();                     // pc now 4

        // ---- reset during a pending misalign pulse
        pc_ready_i    = 1'b0;
        imm_i         = 32'h0000_0001;
        redir_valid_i = 1'b1;
        cyc();                     // misalign_o high now
        redir_valid_i = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("midrst_pc",       pc_o,            32'h8000_0000);
        check("midrst_valid",    pc_valid_o,      1'b0);
        check("midrst_misalign", misalign_o,      1'b0);
        check("midrst_mis_addr", misalign_addr_o, 32'h0);
`ifdef PC_GEN_PERF_EN
        check("midrst_perf_fetch", perf_fetch_o, 64'd0);
        check("midrst_perf_redir", perf_redir_o, 64'd0);
`endif
        cyc();
        cyc();

        // ---- restart after reset
        fetch_q.push_back(32'h8000_0000);
        rst_n      = 1'b1;
        pc_ready_i = 1'b1;
        cyc();                     // RUN, pc 8000_0000
        cyc();                     // handshake taken, pc 8000_0004
        pc_ready_i = 1'b0;
        @(negedge clk);
        check("restart_pc", pc_o, 32'h8000_0004);
`ifdef PC_GEN_PERF_EN
        check("restart_perf_fetch", perf_fetch_o, 64'd1);
`endif
        cyc();

        check("fetch_q_empty", 64'(fetch_q.size()), 64'd0);
        check("mis_q_empty",   64'(mis_q.size()),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
